sdpram_rd_stream: RTL and testbench

//  Read-side controller for the switch's simple dual-port buffer RAM (1W/1R, single clock here).

---
 rtl/sdpram_rd_stream.sv | 141 ++++++++++++++
 tb/tb_sdpram_rd_stream.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdpram_rd_stream.sv
// Read-side streamer for the simple dual-port buffer RAM: walks a descriptor's
// address range, hides the 2-cycle read latency and emits a valid/ready stream.
module sdpram_rd_stream #(
   parameter int DWIDTH     = 18,
   parameter int AWIDTH     = 10,
   parameter int LWIDTH     = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              desc_valid,
   output logic              desc_ready,
   input  logic [AWIDTH-1:0] desc_addr,
   input  logic [LWIDTH-1:0] desc_len,
   output logic              rd_en_b,
   output logic [AWIDTH-1:0] rd_addr_b,
   input  logic [DWIDTH-1:0] rd_data_b,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [DWIDTH-1:0] dout_data,
   output logic              dout_last,
   output logic              done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t            state_q;
   logic [AWIDTH-1:0] nextAddr_q;
   logic [AWIDTH-1:0] lastAddr_q;
   logic [LWIDTH-1:0] remain_q;
   logic              done_q;
   logic              p1_q, p2_q;
   logic              l1_q, l2_q;

   logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];
   logic              memLast_q [FIFO_DEPTH];
   logic [PW-1:0]     wrPtr_q, rdPtr_q;
   logic [CW-1:0]     count_q, count_d;

   logic [CW:0]       occupancy;
   logic              creditOk, issue, push, pop;

   // Every word in flight already owns a FIFO slot, so the FIFO can never overflow.
   assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, p1_q} + {{CW{1'b0}}, p2_q};
   assign creditOk  = occupancy < (CW+1)'(FIFO_DEPTH);
   assign issue     = (state_q == ISSUE) && creditOk;
   assign push      = p2_q;
   assign pop       = dout_valid && dout_ready;

   assign desc_ready = (state_q == IDLE);
   assign rd_en_b    = issue;
   assign rd_addr_b  = issue ? nextAddr_q : lastAddr_q;
   assign dout_valid = (count_q != '0);
   assign dout_data  = mem_q[rdPtr_q];
   assign dout_last  = memLast_q[rdPtr_q];
   assign done       = done_q;

   // Descriptor FSM, read issue and the 2-stage latency tracker carrying the last tag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         nextAddr_q <= '0;
         lastAddr_q <= '0;
         remain_q   <= '0;
         done_q     <= 1'b0;
         p1_q       <= 1'b0;
         p2_q       <= 1'b0;
         l1_q       <= 1'b0;
         l2_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         p1_q   <= issue;
         l1_q   <= issue && (remain_q == LWIDTH'(1));
         p2_q   <= p1_q;
         l2_q   <= l1_q;
         if (issue) begin
            lastAddr_q <= nextAddr_q;
            nextAddr_q <= nextAddr_q + AWIDTH'(1);
            remain_q   <= remain_q - LWIDTH'(1);
         end
         case (state_q)
            IDLE: begin
               if (desc_valid) begin
                  if (desc_len != '0) begin
                     nextAddr_q <= desc_addr;
                     remain_q   <= desc_len;
                     state_q    <= ISSUE;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (issue && (remain_q == LWIDTH'(1))) state_q <= DRAIN;
            end
            DRAIN: begin
               if (pop && dout_last) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Output FIFO; the head entry is a register so the stream holds steady under back-pressure.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i]     <= '0;
            memLast_q[i] <= 1'b0;
         end
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         assert (!(push && !pop && (count_q == CW'(FIFO_DEPTH))));
         if (push) begin
            mem_q[wrPtr_q]     <= rd_data_b;
            memLast_q[wrPtr_q] <= l2_q;
            wrPtr_q            <= wrPtr_q + PW'(1);
         end
         if (pop) rdPtr_q <= rdPtr_q + PW'(1);
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_sdpram_rd_stream.sv
// Bench for sdpram_rd_stream: behavioural 2-cycle RAM, scoreboard of expected
// stream words, and a negedge monitor that logs reads, handshakes and done pulses.
module tb_sdpram_rd_stream;

   localparam int DW = 18;
   localparam int AW = 10;
   localparam int LW = 10;
   localparam int FD = 4;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          desc_valid;
   logic          desc_ready;
   logic [AW-1:0] desc_addr;
   logic [LW-1:0] desc_len;
   logic          rd_en_b;
   logic [AW-1:0] rd_addr_b;
   logic [DW-1:0] rd_data_b;
   logic          dout_valid;
   logic          dout_ready;
   logic [DW-1:0] dout_data;
   logic          dout_last;
   logic          done;

   logic [DW-1:0] ram [1024];
   logic [DW-1:0] ramStage;

   int    cyc = 0;
   int    checks = 0;
   int    failures = 0;
   word_t expQ[$];
   int    addrLog[$];
   int    rdCyc[$];
   int    hsCyc[$];
   int    doneCyc[$];
   int    validCnt = 0;
   logic          holdPrev = 1'b0;
   logic [DW-1:0] prevData;
   logic          prevLast;

   sdpram_rd_stream #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst),
      .desc_valid(desc_valid), .desc_ready(desc_ready),
      .desc_addr(desc_addr), .desc_len(desc_len),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .dout_valid(dout_valid), .dout_ready(dout_ready),
      .dout_data(dout_data), .dout_last(dout_last), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM read port with two register stages of latency.
   always @(posedge clk) begin
      if (rd_en_b) ramStage <= ram[rd_addr_b];
      rd_data_b <= ramStage;
   end

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: samples at negedge, pops the scoreboard on each stream handshake.
   always @(negedge clk) begin
      if (rst) begin
         holdPrev = 1'b0;
      end else begin
         if (rd_en_b) begin
            addrLog.push_back(int'(rd_addr_b));
            rdCyc.push_back(cyc);
         end
         if (done) doneCyc.push_back(cyc);
         if (dout_valid) validCnt++;
         if (holdPrev) begin
            checkOutput("stable_data", dout_data, prevData);
            checkOutput("stable_last", dout_last, prevLast);
         end
         holdPrev = dout_valid && !dout_ready;
         prevData = dout_data;
         prevLast = dout_last;
         if (dout_valid && dout_ready) begin
            hsCyc.push_back(cyc);
            if (expQ.size() == 0) begin
               checkOutput("unexpected_word", dout_data, -1);
            end else begin
               word_t w;
               w = expQ.pop_front();
               checkOutput("dout_data", dout_data, w.data);
               checkOutput("dout_last", dout_last, w.last);
            end
         end
      end
   end

   task automatic clearLogs();
      addrLog.delete();
      rdCyc.delete();
      hsCyc.delete();
      doneCyc.delete();
      validCnt = 0;
   endtask

   // Offers a descriptor until accepted; returns aligned just after the accepting edge.
   task automatic applyStimulus(input int addr, input int len, output int acceptCyc);
      word_t w;
      desc_valid = 1'b1;
      desc_addr  = AW'(addr);
      desc_len   = LW'(len);
      acceptCyc  = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (desc_ready) begin
            acceptCyc = cyc;
            break;
         end
      end
      if (acceptCyc < 0) begin
         checkOutput("desc_accept_timeout", 0, 1);
      end else begin
         for (int i = 0; i < len; i++) begin
            w.data = ram[(addr + i) % 1024];
            w.last = (i == len - 1);
            expQ.push_back(w);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic waitDone(input int target);
      int n;
      n = 0;
      while (doneCyc.size() < target && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      if (doneCyc.size() < target) checkOutput("done_timeout", doneCyc.size(), target);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_desc_ready"}, desc_ready, 1);
      checkOutput({tag, "_rd_en_b"}, rd_en_b, 0);
      checkOutput({tag, "_rd_addr_b"}, rd_addr_b, 0);
      checkOutput({tag, "_dout_valid"}, dout_valid, 0);
      checkOutput({tag, "_dout_data"}, dout_data, 0);
      checkOutput({tag, "_dout_last"}, dout_last, 0);
      checkOutput({tag, "_done"}, done, 0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int t, t1, t2, n;
      logic allReady;

      for (int i = 0; i < 1024; i++) ram[i] = DW'((i * 613) ^ 18'h15A5A);
      ram[10'h010] = 18'h0AAAA;
      ram[10'h011] = 18'h0BBBB;
      ram[10'h012] = 18'h0CCCC;

      rst = 1'b1;
      desc_valid = 1'b0;
      desc_addr = '0;
      desc_len = '0;
      dout_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      rst = 1'b0;
      @(posedge clk); #1;

      $display("[TB] test 1: basic 3-word read and latency");
      clearLogs();
      dout_ready = 1'b1;
      applyStimulus(10'h010, 3, t);
      desc_valid = 1'b0;
      waitDone(1);
      checkOutput("t1_rd_count", rdCyc.size(), 3);
      checkOutput("t1_rd_first", rdCyc.size() > 0 ? rdCyc[0] : -1, t + 1);
      checkOutput("t1_rd_lastc", rdCyc.size() > 2 ? rdCyc[2] : -1, t + 3);
      checkOutput("t1_hs_count", hsCyc.size(), 3);
      checkOutput("t1_hs_first", hsCyc.size() > 0 ? hsCyc[0] : -1, t + 4);
      checkOutput("t1_hs_lastc", hsCyc.size() > 2 ? hsCyc[2] : -1, t + 6);
      checkOutput("t1_done_cyc", doneCyc.size() > 0 ? doneCyc[0] : -1, t + 7);
      checkOutput("t1_scoreboard_empty", expQ.size(), 0);

      $display("[TB] test 2: address wrap");
      clearLogs();
      applyStimulus(10'h3FE, 4, t);
      desc_valid = 1'b0;
      waitDone(1);
      checkOutput("t2_rd_count", addrLog.size(), 4);
      checkOutput("t2_addr0", addrLog.size() > 0 ? addrLog[0] : -1, 10'h3FE);
      checkOutput("t2_addr1", addrLog.size() > 1 ? addrLog[1] : -1, 10'h3FF);
      checkOutput("t2_addr2", addrLog.size() > 2 ? addrLog[2] : -1, 10'h000);
      checkOutput("t2_addr3", addrLog.size() > 3 ? addrLog[3] : -1, 10'h001);
      checkOutput("t2_scoreboard_empty", expQ.size(), 0);

      $display("[TB] test 3: back-pressure and credit limit");
      clearLogs();
      dout_ready = 1'b0;
      applyStimulus(10'h000, 16, t);
      desc_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t3_reads_while_stalled", rdCyc.size(), FD);
      checkOutput("t3_valid_held", dout_valid, 1);
      checkOutput("t3_word0_held", dout_data, ram[0]);
      checkOutput("t3_last_low", dout_last, 0);
      n = 0;
      while (doneCyc.size() < 1 && n < 600) begin
         dout_ready = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         n++;
      end
      dout_ready = 1'b1;
      checkOutput("t3_done_seen", doneCyc.size(), 1);
      checkOutput("t3_rd_count", addrLog.size(), 16);
      checkOutput("t3_hs_count", hsCyc.size(), 16);
      checkOutput("t3_scoreboard_empty", expQ.size(), 0);

      $display("[TB] test 4: zero-length descriptor");
      clearLogs();
      applyStimulus(10'h055, 0, t);
      desc_valid = 1'b0;
      allReady = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (!desc_ready) allReady = 1'b0;
      end
      @(posedge clk); #1;
      checkOutput("t4_desc_ready_high", allReady, 1);
      checkOutput("t4_done_count", doneCyc.size(), 1);
      checkOutput("t4_done_cyc", doneCyc.size() > 0 ? doneCyc[0] : -1, t + 1);
      checkOutput("t4_no_reads", rdCyc.size(), 0);
      checkOutput("t4_no_valid", validCnt, 0);

      $display("[TB] test 5: reset mid-stream");
      clearLogs();
      applyStimulus(10'h100, 8, t);
      desc_valid = 1'b0;
      n = 0;
      while (hsCyc.size() < 2 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput("t5_two_words_before_reset", hsCyc.size(), 2);
      rst = 1'b1;
      #1;
      checkResetOutputs("midreset");
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      clearLogs();
      applyStimulus(10'h200, 2, t);
      desc_valid = 1'b0;
      waitDone(1);
      checkOutput("t5_post_reset_words", hsCyc.size(), 2);
      checkOutput("t5_scoreboard_empty", expQ.size(), 0);

      $display("[TB] test 6: back-to-back descriptors");
      clearLogs();
      applyStimulus(10'h020, 3, t1);
      applyStimulus(10'h030, 2, t2);
      desc_valid = 1'b0;
      waitDone(2);
      checkOutput("t6_second_accept_in_done", t2, doneCyc.size() > 0 ? doneCyc[0] : -1);
      checkOutput("t6_done_after_last_hs", doneCyc.size() > 0 ? doneCyc[0] : -1,
                  hsCyc.size() > 2 ? hsCyc[2] + 1 : -2);
      checkOutput("t6_second_done_cyc", doneCyc.size() > 1 ? doneCyc[1] : -1, t2 + 6);
      checkOutput("t6_hs_count", hsCyc.size(), 5);
      checkOutput("t6_scoreboard_empty", expQ.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
